mul_seq_ctrl: RTL

//  Iterative shift-add multiplier controller for the EX stage: sequences one shared ADD32 instance
//  (instantiated at WIDTH+1 bits) over WIDTH cycles to form a 2*WIDTH-bit product for MULT/MULTU.

---
 rtl/mul_seq_ctrl_pkg.sv | 13 +
 rtl/mul_seq_ctrl_add32.sv | 13 +
 rtl/mul_seq_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the iterative shift-add multiplier controller:
// FSM state encoding and the default operand width.
package mul_seq_ctrl_pkg;

   localparam int MUL_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

endpackage : mul_seq_ctrl_pkg

// File: rtl/mul_seq_ctrl_add32.sv
// Plain ripple adder shared by the multiplier datapath; instantiated one bit
// wider than the operands so the partial-product carry-out is kept.
module mul_seq_ctrl_add32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o
);

   assign sum_o = a_i + b_i;

endmodule : mul_seq_ctrl_add32

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add MULT/MULTU controller: one partial-product add per cycle,
// WIDTH cycles per product, result latched into HI/LO on completion.
module mul_seq_ctrl
   import mul_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output mul_state_e       dbg_state
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mul_state_e         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   mc_q;
   logic [2*WIDTH-1:0] p_q;
   logic               neg_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     add_a;
   logic [WIDTH:0]     add_b;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] p_d;
   logic [2*WIDTH-1:0] prod_d;
   logic               accept;
   logic               last;
   logic               finish;

   // Operand magnitudes and final sign fix-up use local incrementers,
   // keeping the shared adder dedicated to the partial-product add.
   always_comb begin
      abs_a  = (sign & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      abs_b  = (sign & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      add_a  = {1'b0, p_q[2*WIDTH-1:WIDTH]};
      add_b  = {1'b0, mc_q};
      sum    = p_q[0] ? add_sum : add_a;
      p_d    = {sum, p_q[WIDTH-1:1]};
      prod_d = neg_q ? (~p_d + (2*WIDTH)'(1)) : p_d;
   end

   mul_seq_ctrl_add32 #(
      .WIDTH(WIDTH + 1)
   ) u_add (
      .a_i  (add_a),
      .b_i  (add_b),
      .sum_o(add_sum)
   );

   assign accept = start & ~flush & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign last   = (cnt_q == CNT_LAST);
   assign finish = (state_q == ST_RUN) & ~flush & last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mc_q    <= '0;
         p_q     <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (accept) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  mc_q    <= abs_a;
                  p_q     <= {{WIDTH{1'b0}}, abs_b};
                  neg_q   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (flush) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  p_q   <= p_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // HI/LO only move on a clean completion; a flushed operation leaves them intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (finish) begin
         hi_q <= prod_d[2*WIDTH-1:WIDTH];
         lo_q <= prod_d[WIDTH-1:0];
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign dbg_state = state_q;

endmodule : mul_seq_ctrl
